x74_logic_array: RTL and testbench
==================================

// Module: x74_logic_array
// PURPOSE
//  Parametrised successor to the fixed quad AND2 gate chip: CHANNELS independent 2-input gates,
//  each WIDTH bits wide, with a run-time selectable function per channel and registered outputs.
//  The function table is loaded through a bit-serial configuration port with an atomic commit,
//  so the gate functions never change mid-load. Sits at chip top, directly behind the I/O pads.
// PARAMETERS
//  CHANNELS  4  number of gate channels (>=1)
//  WIDTH     1  bits per channel operand (>=1); the gate is applied bitwise
// PORTS
//  clk        in   1               core clock, all state on rising edge
//  nreset     in   1               asynchronous active-low reset
//  a          in   CHANNELS*WIDTH  operand A; channel i = a[i*WIDTH +: WIDTH]
//  b          in   CHANNELS*WIDTH  operand B, same packing as a
//  y          out  CHANNELS*WIDTH  registered gate result, same packing
//  cfg_start  in   1               pulse: begin a configuration load
//  cfg_valid  in   1               cfg_sdi carries a valid bit this cycle
//  cfg_sdi    in   1               serial configuration data
//  cfg_abort  in   1               abandon an in-progress load
//  cfg_busy   out  1               high in SHIFT and COMMIT
//  cfg_done   out  1               one-cycle pulse on COMMIT
//  cfg_sdo    out  1               readback data (only with LOGIC_ARRAY_READBACK_EN)
// BEHAVIOUR
//  - Reset (nreset low, async): y=0, cfg_busy=0, cfg_done=0, cfg_sdo=0, state=IDLE, bit counter=0,
//    every func[i]=2'b00 (AND), shadow register=0. Leaving reset takes effect on the next clk edge.
//  - Function codes (2 bits per channel): 00 AND, 01 OR, 10 XOR, 11 NAND.
//  - Datapath: every cycle y[ch] <= f(func[ch], a[ch], b[ch]); latency 1 clk; not stalled by config.
//  - FSM states: IDLE, SHIFT, COMMIT.
//    IDLE:   cfg_start=1 -> SHIFT, counter=0. cfg_valid/cfg_sdi/cfg_abort ignored.
//    SHIFT:  cfg_abort=1 -> IDLE; shadow discarded, func unchanged; abort takes priority over valid.
//            else cfg_valid=1 -> shadow <= {shadow[2*CHANNELS-2:0], cfg_sdi}, counter+1;
//            on the valid bit where counter==2*CHANNELS-1 -> COMMIT. cfg_valid=0 -> hold (no timeout).
//            cfg_start in SHIFT is ignored (no restart).
//    COMMIT: func <= shadow, cfg_done=1 for this one cycle, -> IDLE unconditionally.
//  - Bit order: first bit shifted in ends up as MSB = func[CHANNELS-1][1]; last bit = func[0][0].
//  - func updates at the clk edge ending COMMIT; y reflects the new functions at the following edge.
//    The y computed at the edge ending COMMIT still uses the old func.
//  - cfg_busy is registered: high the cycle after cfg_start is accepted, low the cycle after COMMIT.
//  - Counter width $clog2(2*CHANNELS), minimum 1 bit; it never wraps, because COMMIT exits first.
//  - Reset asserted mid-load returns to IDLE with all funcs = AND; partial shadow is lost.
// CONFIGURATION
//  LOGIC_ARRAY_READBACK_EN defined:
//    - cfg_sdo port present.
//    - On cfg_start, shadow is preloaded with the current func table.
//    - cfg_sdo = shadow MSB, registered; it shifts out the old table, MSB first, while new bits
//      shift in. This allows daisy-chaining several arrays.
//    - cfg_sdo = 0 in IDLE.
//  Not defined:
//    - cfg_sdo port absent.
//    - On cfg_start, shadow is cleared to 0; there is no readback path.
// TESTING
//  1. Reset release, CHANNELS=4, WIDTH=1, a=4'b1100, b=4'b1010 -> after 1 clk y=4'b1000 (all AND).
//  2. Load 8 bits 11_10_01_00 (ch3 NAND, ch2 XOR, ch1 OR, ch0 AND).
//     -> cfg_done pulses once; cfg_busy spans 9 cycles.
//     -> With the same a and b, y=4'b0110 two clks after COMMIT; y is unchanged before that.
//  3. Load with 3 idle cycles (cfg_valid=0) inserted between bits -> same result as test 2;
//     cfg_busy stays high throughout.
//  4. Assert cfg_abort after 5 valid bits -> IDLE next cycle, no cfg_done, y still the AND result.
//     A second cfg_start in SHIFT is ignored.
//  5. Assert nreset mid-SHIFT after a prior NAND load -> y=0 and cfg_busy=0 immediately (async);
//     funcs revert to AND.
//  6. READBACK_EN: table 11_10_01_00 loaded, then load 00_00_00_00 -> cfg_sdo emits 1,1,1,0,0,1,0,0.
//     WIDTH=8, CHANNELS=2: XOR with a=8'hF0, b=8'h3C -> y=8'hCC.

Source files
------------

// File: rtl/x74_logic_array.sv
// CHANNELS independent WIDTH-bit 2-input gates with registered outputs and a serially loaded,
// atomically committed function table. Optional readback/daisy-chain: LOGIC_ARRAY_READBACK_EN.
module x74_logic_array #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic [CHANNELS*WIDTH-1:0] y,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic                      cfg_sdi,
    input  logic                      cfg_abort,
    output logic                      cfg_busy,
    output logic                      cfg_done
`ifdef LOGIC_ARRAY_READBACK_EN
    ,
    output logic                      cfg_sdo
`endif
);

    localparam int unsigned DW    = CHANNELS * WIDTH;
    localparam int unsigned FW    = 2 * CHANNELS;
    localparam int unsigned CNT_W = (FW > 2) ? $clog2(FW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [FW-1:0]    shadow;
    logic [FW-1:0]    func_q;
    logic [DW-1:0]    y_next;

    function automatic logic [WIDTH-1:0] gate(input logic [1:0]       fn,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
        case (fn)
            2'b00:   gate = x & z;
            2'b01:   gate = x | z;
            2'b10:   gate = x ^ z;
            default: gate = ~(x & z);
        endcase
    endfunction

    // Per-channel gate evaluation with the currently committed function table
    always_comb begin
        y_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            y_next[i*WIDTH +: WIDTH] = gate(func_q[2*i +: 2], a[i*WIDTH +: WIDTH],
                                            b[i*WIDTH +: WIDTH]);
        end
    end

    // Datapath register plus configuration FSM; func_q only changes on leaving COMMIT
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            y        <= '0;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shadow   <= '0;
            func_q   <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
`ifdef LOGIC_ARRAY_READBACK_EN
            cfg_sdo  <= 1'b0;
`endif
        end else begin
            y        <= y_next;
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state    <= ST_SHIFT;
                        bit_cnt  <= '0;
                        cfg_busy <= 1'b1;
`ifdef LOGIC_ARRAY_READBACK_EN
                        shadow   <= func_q;
                        cfg_sdo  <= func_q[FW-1];
`else
                        shadow   <= '0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (cfg_abort) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        shadow   <= '0;
                        cfg_busy <= 1'b0;
`ifdef LOGIC_ARRAY_READBACK_EN
                        cfg_sdo  <= 1'b0;
`endif
                    end else if (cfg_valid) begin
                        shadow <= {shadow[FW-2:0], cfg_sdi};
`ifdef LOGIC_ARRAY_READBACK_EN
                        cfg_sdo <= shadow[FW-2];
`endif
                        // Last bit goes straight to COMMIT so the counter never wraps
                        if (bit_cnt == CNT_W'(FW - 1)) begin
                            state    <= ST_COMMIT;
                            bit_cnt  <= '0;
                            cfg_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    func_q   <= shadow;
                    state    <= ST_IDLE;
                    cfg_busy <= 1'b0;
`ifdef LOGIC_ARRAY_READBACK_EN
                    cfg_sdo  <= 1'b0;
`endif
                end
                default: begin
                    state    <= ST_IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x74_logic_array.sv
// Directed bench for x74_logic_array: default 4x1 instance plus a 2x8 instance.
module tb_x74_logic_array;

    logic        clk;
    logic        nreset;
    logic [3:0]  a, b, y;
    logic        cfg_start, cfg_valid, cfg_sdi, cfg_abort, cfg_busy, cfg_done;
    logic [15:0] a2, b2, y2;
    logic        cfg2_start, cfg2_valid, cfg2_sdi, cfg2_busy, cfg2_done;
`ifdef LOGIC_ARRAY_READBACK_EN
    logic        cfg_sdo, cfg2_sdo;
`endif

    int total = 0;
    int bad   = 0;
    int busy_seen = 0;
    int done_seen = 0;

    x74_logic_array #(.CHANNELS(4), .WIDTH(1)) dut (
        .clk(clk), .nreset(nreset), .a(a), .b(b), .y(y),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_sdi(cfg_sdi),
        .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
`ifdef LOGIC_ARRAY_READBACK_EN
        , .cfg_sdo(cfg_sdo)
`endif
    );

    x74_logic_array #(.CHANNELS(2), .WIDTH(8)) dut2 (
        .clk(clk), .nreset(nreset), .a(a2), .b(b2), .y(y2),
        .cfg_start(cfg2_start), .cfg_valid(cfg2_valid), .cfg_sdi(cfg2_sdi),
        .cfg_abort(1'b0), .cfg_busy(cfg2_busy), .cfg_done(cfg2_done)
`ifdef LOGIC_ARRAY_READBACK_EN
        , .cfg_sdo(cfg2_sdo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tallies of busy cycles and done pulses seen on dut
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            if (cfg_busy === 1'b1) busy_seen++;
            if (cfg_done === 1'b1) done_seen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start, optional idle gap before each bit, 8 bits MSB first; returns right after the COMMIT-entry edge
    task automatic load(input logic [7:0] bits, input int gap);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_sdi   = bits[i];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    initial begin
        int          b0, d0;
        logic [7:0]  tbl;
        logic [3:0]  bits2;
        nreset = 1'b0;
        a = 4'b1100; b = 4'b1010;
        a2 = 16'hF0F0; b2 = 16'h3C3C;
        cfg_start = 0; cfg_valid = 0; cfg_sdi = 0; cfg_abort = 0;
        cfg2_start = 0; cfg2_valid = 0; cfg2_sdi = 0;
        tick(); tick();
        check("rst_y", 16'(y), 16'h0);
        check("rst_busy", 16'(cfg_busy), 16'h0);
        check("rst_done", 16'(cfg_done), 16'h0);

        // 1: all-AND after reset
        nreset = 1'b1;
        tick();
        check("t1_and_y", 16'(y), 16'h8);
        check("t1_w8_and_y", y2, 16'h3030);

        // 2: load NAND/XOR/OR/AND, continuous bits
        b0 = busy_seen; d0 = done_seen;
        load(8'b11_10_01_00, 0);
        check("t2_done_hi", 16'(cfg_done), 16'h1);
        check("t2_busy_commit", 16'(cfg_busy), 16'h1);
        check("t2_y_old_commit", 16'(y), 16'h8);
        tick();
        check("t2_done_lo", 16'(cfg_done), 16'h0);
        check("t2_busy_lo", 16'(cfg_busy), 16'h0);
        check("t2_y_old_after", 16'(y), 16'h8);
        tick();
        check("t2_y_new", 16'(y), 16'h6);
        check("t2_busy_cycles", 16'(busy_seen - b0), 16'd9);
        check("t2_done_pulses", 16'(done_seen - d0), 16'd1);

        // back to all-AND
        load(8'h00, 0);
        tick(); tick();
        check("reload_and_y", 16'(y), 16'h8);

        // 3: same table with 3 idle cycles before each bit
        b0 = busy_seen; d0 = done_seen;
        load(8'b11_10_01_00, 3);
        check("t3_done_hi", 16'(cfg_done), 16'h1);
        tick(); tick();
        check("t3_y_new", 16'(y), 16'h6);
        check("t3_busy_cycles", 16'(busy_seen - b0), 16'd33);
        check("t3_done_pulses", 16'(done_seen - d0), 16'd1);

        load(8'h00, 0);
        tick(); tick();

        // 4a: abort after 5 valid bits (abort wins over valid)
        d0 = done_seen;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_sdi = 1'b1;
            tick();
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("t4_abort_busy", 16'(cfg_busy), 16'h0);
        for (int i = 0; i < 4; i++) tick();
        cfg_valid = 1'b0; cfg_sdi = 1'b0;
        check("t4_idle_busy", 16'(cfg_busy), 16'h0);
        check("t4_no_done", 16'(done_seen - d0), 16'd0);
        check("t4_y_and", 16'(y), 16'h8);

        // 4b: second cfg_start mid-SHIFT must not restart the count
        tbl = 8'b11_10_01_00;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cfg_valid = 1'b1; cfg_sdi = tbl[i];
            cfg_start = (i == 3);
            tick();
        end
        cfg_valid = 1'b0; cfg_start = 1'b0; cfg_sdi = 1'b0;
        check("t4_restart_done", 16'(cfg_done), 16'h1);
        tick(); tick();
        check("t4_restart_y", 16'(y), 16'h6);

        // 5: all-NAND, then async reset mid-SHIFT
        load(8'hFF, 0);
        tick(); tick();
        check("t5_nand_y", 16'(y), 16'h7);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_sdi = 1'b1;
            tick();
        end
        check("t5_busy_pre", 16'(cfg_busy), 16'h1);
        #2 nreset = 1'b0;
        #1;
        check("t5_rst_y", 16'(y), 16'h0);
        check("t5_rst_busy", 16'(cfg_busy), 16'h0);
        check("t5_rst_w8_y", y2, 16'h0);
        cfg_valid = 1'b0; cfg_sdi = 1'b0;
        @(posedge clk);
        #1 nreset = 1'b1;
        tick();
        check("t5_and_y", 16'(y), 16'h8);
        check("t5_busy_idle", 16'(cfg_busy), 16'h0);

        // 6: 2x8 instance, both channels XOR
        bits2 = 4'b10_10;
        cfg2_start = 1'b1;
        tick();
        cfg2_start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cfg2_valid = 1'b1; cfg2_sdi = bits2[i];
            tick();
        end
        cfg2_valid = 1'b0; cfg2_sdi = 1'b0;
        check("t6_w8_done", 16'(cfg2_done), 16'h1);
        tick(); tick();
        check("t6_w8_xor_y", y2, 16'hCCCC);

`ifdef LOGIC_ARRAY_READBACK_EN
        // Readback of the old table while loading zeros
        load(8'b11_10_01_00, 0);
        tick(); tick();
        check("rb_idle_sdo", 16'(cfg_sdo), 16'h0);
        tbl = 8'b11_10_01_00;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("rb_sdo_0", 16'(cfg_sdo), 16'(tbl[7]));
        for (int k = 1; k < 8; k++) begin
            cfg_valid = 1'b1; cfg_sdi = 1'b0;
            tick();
            check($sformatf("rb_sdo_%0d", k), 16'(cfg_sdo), 16'(tbl[7-k]));
        end
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("rb_sdo_idle_after", 16'(cfg_sdo), 16'h0);
        tick();
        check("rb_zero_y", 16'(y), 16'h8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
